// File: rtl/xbus_mem_responder.sv
// xbus_mem_responder
//   XBUS (Wishbone-style) slave that terminates the processor bus with a word
//   memory. Byte enables apply to writes. A programmable number of wait
//   states is inserted before each ack/err. Any access outside the address
//   window gets an err response. Saturating counters track completed reads,
//   completed writes and err responses. Only one transaction is in flight at
//   a time.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   xbus_adr_i   byte address (bits [1:0] ignored)
//   xbus_dat_i   write data
//   xbus_tag_i   access tag (no effect)
//   xbus_we_i    1 = write
//   xbus_sel_i   byte enables
//   xbus_stb_i   single-cycle request strobe
//   xbus_cyc_i   cycle valid, held until ack/err; dropping it aborts
//   xbus_dat_o   read data, meaningful only while xbus_ack_o = 1
//   xbus_ack_o   one-cycle success pulse
//   xbus_err_o   one-cycle error pulse (address outside the window)
//   rd_cnt_o     completed reads, saturating
//   wr_cnt_o     completed writes, saturating
//   err_cnt_o    err responses, saturating
//   proto_err_o  sticky: strobe while busy, or strobe without cyc
module xbus_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int unsigned AW        = 10,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      xbus_adr_i,
  input  logic [31:0]      xbus_dat_i,
  input  logic [2:0]       xbus_tag_i,
  input  logic             xbus_we_i,
  input  logic [3:0]       xbus_sel_i,
  input  logic             xbus_stb_i,
  input  logic             xbus_cyc_i,
  output logic [31:0]      xbus_dat_o,
  output logic             xbus_ack_o,
  output logic             xbus_err_o,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             proto_err_o
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       wcnt_q;
  logic [AW-1:0]    idx_q;
  logic [31:0]      wdat_q;
  logic             we_q;
  logic [3:0]       sel_q;
  logic             hit_q;
  logic [31:0]      dat_q;
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q, err_cnt_q;
  logic             proto_q;

  logic [31:0]      mem [DEPTH];

  logic             req_hit;
  logic             start;
  logic             complete;
  logic             unused_bits;

  // Tag and the byte offset inside a word carry no meaning for this slave.
  assign unused_bits = ^{xbus_tag_i, xbus_adr_i[1:0]};

  assign req_hit  = (xbus_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign start    = (state_q == S_IDLE) && xbus_stb_i && xbus_cyc_i;
  // The response edge: wait counter exhausted and the master still holds cyc.
  assign complete = (state_q == S_WAIT) && xbus_cyc_i && (wcnt_q == '0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    xbus_ack_o = 1'b0;
    xbus_err_o = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_WAIT;
      S_WAIT: begin
        if (!xbus_cyc_i)        state_d = S_IDLE;
        else if (wcnt_q == '0)  state_d = S_RESP;
      end
      S_RESP: begin
        state_d    = S_IDLE;
        xbus_ack_o = hit_q;
        xbus_err_o = !hit_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      idx_q     <= '0;
      wdat_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      hit_q     <= 1'b0;
      dat_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
      proto_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start) begin
        idx_q  <= xbus_adr_i[AW+1:2];
        wdat_q <= xbus_dat_i;
        we_q   <= xbus_we_i;
        sel_q  <= xbus_sel_i;
        hit_q  <= req_hit;
        wcnt_q <= 4'(LATENCY);
      end else if ((state_q == S_WAIT) && (wcnt_q != '0)) begin
        wcnt_q <= wcnt_q - 4'd1;
      end

      if (complete) begin
        dat_q <= (hit_q && !we_q) ? mem[idx_q] : '0;
        if (!hit_q)    err_cnt_q <= sat_inc(err_cnt_q);
        else if (we_q) wr_cnt_q  <= sat_inc(wr_cnt_q);
        else           rd_cnt_q  <= sat_inc(rd_cnt_q);
      end else if (state_q == S_RESP) begin
        dat_q <= '0;
      end

      // The offending strobe itself is simply not acted upon elsewhere.
      if (xbus_stb_i && ((state_q != S_IDLE) || !xbus_cyc_i)) proto_q <= 1'b1;
    end
  end

  // Memory has no reset; complete is low while in reset because state_q is IDLE.
  always_ff @(posedge clk_i) begin
    if (complete && hit_q && we_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
      end
    end
  end

  assign xbus_dat_o  = dat_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign err_cnt_o   = err_cnt_q;
  assign proto_err_o = proto_q;

endmodule

// File: tb/tb_xbus_mem_responder.sv
// Bench for xbus_mem_responder. Instance A (LATENCY=2, 4-bit counters) is
// tracked cycle by cycle against a transaction-level model; instance B
// (LATENCY=4) covers reset arriving in the middle of a wait.
module tb_xbus_mem_responder;

  localparam int unsigned LAT_A = 2;
  localparam int unsigned LAT_B = 4;
  localparam int unsigned CW_A  = 4;
  localparam int unsigned CW_B  = 16;
  localparam int          CMAX  = (1 << CW_A) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [2:0]  tag = '0;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        stb_a = 1'b0, cyc_a = 1'b0, stb_b = 1'b0, cyc_b = 1'b0;

  logic [31:0]     a_dat, b_dat;
  logic            a_ack, a_err, a_proto, b_ack, b_err, b_proto;
  logic [CW_A-1:0] a_rd, a_wr, a_ec;
  logic [CW_B-1:0] b_rd, b_wr, b_ec;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xbus_mem_responder #(.BASE_ADDR(32'h9000_0000), .AW(10), .LATENCY(LAT_A), .CNT_W(CW_A)) dut_a (
    .clk_i(clk), .rst_i(rst), .xbus_adr_i(adr), .xbus_dat_i(wdat), .xbus_tag_i(tag),
    .xbus_we_i(we), .xbus_sel_i(sel), .xbus_stb_i(stb_a), .xbus_cyc_i(cyc_a),
    .xbus_dat_o(a_dat), .xbus_ack_o(a_ack), .xbus_err_o(a_err),
    .rd_cnt_o(a_rd), .wr_cnt_o(a_wr), .err_cnt_o(a_ec), .proto_err_o(a_proto));

  xbus_mem_responder #(.BASE_ADDR(32'h9000_0000), .AW(10), .LATENCY(LAT_B), .CNT_W(CW_B)) dut_b (
    .clk_i(clk), .rst_i(rst), .xbus_adr_i(adr), .xbus_dat_i(wdat), .xbus_tag_i(tag),
    .xbus_we_i(we), .xbus_sel_i(sel), .xbus_stb_i(stb_b), .xbus_cyc_i(cyc_b),
    .xbus_dat_o(b_dat), .xbus_ack_o(b_ack), .xbus_err_o(b_err),
    .rd_cnt_o(b_rd), .wr_cnt_o(b_wr), .err_cnt_o(b_ec), .proto_err_o(b_proto));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model for instance A ----------------
  logic [31:0]     mem_m [0:1023];
  bit   [3:0]      mval  [0:1023];
  int              edge_n, m_due;
  bit              m_active, m_hit, m_we;
  logic [9:0]      m_idx;
  logic [31:0]     m_dat;
  logic [3:0]      m_sel;
  logic            exp_ack, exp_err, exp_proto;
  logic [31:0]     exp_dat;
  bit              exp_dat_known;
  logic [CW_A-1:0] exp_rd, exp_wr, exp_ec;

  function automatic bit in_window(input logic [31:0] a);
    return (a >= 32'h9000_0000) && (a <= 32'h9000_0FFF);
  endfunction

  function automatic logic [CW_A-1:0] sat(input logic [CW_A-1:0] v);
    return (int'(v) < CMAX) ? CW_A'(int'(v) + 1) : v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // A request strobed at edge n is answered at edge n+1+LAT_A provided cyc is
  // still high at every edge up to then; the edge after that ends the busy span.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_n <= 0; m_due <= 0; m_active <= 0;
      exp_ack <= 0; exp_err <= 0; exp_dat <= '0; exp_dat_known <= 1;
      exp_rd <= '0; exp_wr <= '0; exp_ec <= '0; exp_proto <= 0;
    end else begin
      edge_n <= edge_n + 1;
      exp_ack <= 0; exp_err <= 0; exp_dat <= '0; exp_dat_known <= 1;
      if (stb_a && (!cyc_a || m_active)) exp_proto <= 1;
      if (m_active) begin
        if ((edge_n + 1 <= m_due) && !cyc_a) begin
          m_active <= 0;
        end else if (edge_n + 1 == m_due) begin
          if (m_hit) begin
            exp_ack <= 1;
            if (m_we) begin
              mem_m[m_idx] <= merge(mem_m[m_idx], m_dat, m_sel);
              mval[m_idx]  <= mval[m_idx] | m_sel;
              exp_wr       <= sat(exp_wr);
            end else begin
              exp_dat       <= mem_m[m_idx];
              exp_dat_known <= (mval[m_idx] == 4'hF);
              exp_rd        <= sat(exp_rd);
            end
          end else begin
            exp_err <= 1;
            exp_ec  <= sat(exp_ec);
          end
        end else if (edge_n + 1 > m_due) begin
          m_active <= 0;
        end
      end else if (stb_a && cyc_a) begin
        m_active <= 1;
        m_due    <= edge_n + 2 + int'(LAT_A);
        m_hit    <= in_window(adr);
        m_we     <= we;
        m_idx    <= 10'((adr - 32'h9000_0000) >> 2);
        m_dat    <= wdat;
        m_sel    <= sel;
      end
    end
  end

  always @(negedge clk) begin
    chk("ack", 32'(a_ack), 32'(exp_ack));
    chk("err", 32'(a_err), 32'(exp_err));
    if (exp_dat_known) chk("dat", a_dat, exp_dat);
    chk("rd_cnt", 32'(a_rd), 32'(exp_rd));
    chk("wr_cnt", 32'(a_wr), 32'(exp_wr));
    chk("err_cnt", 32'(a_ec), 32'(exp_ec));
    chk("proto", 32'(a_proto), 32'(exp_proto));
  end

  // ---------------- stimulus ----------------
  task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s,
                      input int abort_at, input bit dup, output logic [31:0] rdata, output int lat,
                      output bit got_err, output bit got_resp);
    rdata = '0; lat = 0; got_err = 0; got_resp = 0;
    @(posedge clk); #1;
    adr = a; wdat = d; we = w; sel = s; tag = 3'($urandom);
    stb_a = 1; cyc_a = 1;
    @(posedge clk); #1;
    stb_a = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == abort_at) cyc_a = 0;
      if (dup && i == 2) stb_a = 1;
      @(posedge clk); #1;
      stb_a = 0;
      if (a_ack || a_err) begin
        got_resp = 1; lat = i; rdata = a_dat; got_err = a_err;
        break;
      end
      if (abort_at > 0 && i >= abort_at + 2) break;
    end
    if (got_resp) begin
      @(posedge clk); #1;
      cyc_a = 0;
    end else begin
      cyc_a = 0;
      if (abort_at <= 0) begin
        n_cmp++; n_bad++;
        $display("FAIL resp_timeout: no ack/err for address %h within 40 cycles", a);
      end
    end
  endtask

  logic [31:0] hit_list [9] = '{32'h9000_0000, 32'h9000_0004, 32'h9000_0008, 32'h9000_000C,
                                32'h9000_0010, 32'h9000_0014, 32'h9000_0018, 32'h9000_001C,
                                32'h9000_0FFC};
  logic [31:0] miss_list [3] = '{32'h8000_0000, 32'h9000_1000, 32'h8FFF_FFFC};

  initial begin
    logic [31:0] rd;
    int lat, nresp;
    bit ge, gr;

    #2 rst = 1;
    #1;
    chk("rst_ack", 32'(a_ack), 0);
    chk("rst_dat", a_dat, 0);
    chk("rst_rd_cnt", 32'(a_rd), 0);
    chk("rst_proto", 32'(a_proto), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Instance B: one full write, then reset two wait cycles into a read.
    @(posedge clk); #1;
    adr = 32'h9000_0040; wdat = 32'h0BAD_F00D; we = 1; sel = 4'hF; stb_b = 1; cyc_b = 1;
    @(posedge clk); #1;
    stb_b = 0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (b_ack) begin lat = i; break; end
    end
    chk("b_latency", lat, 5);
    @(posedge clk); #1;
    cyc_b = 0;
    chk("b_wr_cnt", 32'(b_wr), 1);
    @(posedge clk); #1;
    we = 0; stb_b = 1; cyc_b = 1;
    @(posedge clk); #1;
    stb_b = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("b_rst_wr_cnt", 32'(b_wr), 0);
    chk("b_rst_rd_cnt", 32'(b_rd), 0);
    chk("b_rst_err_cnt", 32'(b_ec), 0);
    chk("b_rst_ack", 32'(b_ack), 0);
    chk("b_rst_dat", b_dat, 0);
    chk("b_rst_proto", 32'(b_proto), 0);
    @(posedge clk); #1 rst = 0;
    nresp = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (b_ack || b_err) nresp++;
    end
    chk("b_no_resp_after_reset", nresp, 0);
    cyc_b = 0;

    // Full write and readback.
    xact(32'h9000_0010, 32'hDEAD_BEEF, 1, 4'hF, 0, 0, rd, lat, ge, gr);
    chk("t2_wr_lat", lat, 3);
    chk("t2_wr_ok", 32'({ge, gr}), 1);
    xact(32'h9000_0010, 32'h0, 0, 4'hF, 0, 0, rd, lat, ge, gr);
    chk("t2_rd_data", rd, 32'hDEAD_BEEF);
    chk("t2_rd_lat", lat, 3);
    chk("t2_wr_cnt", 32'(a_wr), 1);
    chk("t2_rd_cnt", 32'(a_rd), 1);

    // Partial write through byte enables.
    xact(32'h9000_0010, 32'h0000_1234, 1, 4'b0011, 0, 0, rd, lat, ge, gr);
    xact(32'h9000_0010, 32'h0, 0, 4'hF, 0, 0, rd, lat, ge, gr);
    chk("t3_rd_data", rd, 32'hDEAD_1234);

    // Miss.
    xact(32'h8000_0000, 32'h0, 0, 4'hF, 0, 0, rd, lat, ge, gr);
    chk("t4_err", 32'({ge, gr}), 3);
    chk("t4_dat", rd, 0);
    chk("t4_err_cnt", 32'(a_ec), 1);
    chk("t4_rd_cnt", 32'(a_rd), 2);

    // Abort after one wait cycle leaves memory and counters untouched.
    xact(32'h9000_0020, 32'hCAFE_F00D, 1, 4'hF, 0, 0, rd, lat, ge, gr);
    xact(32'h9000_0020, 32'h1111_1111, 1, 4'hF, 2, 0, rd, lat, ge, gr);
    chk("t5_abort_no_resp", 32'(gr), 0);
    chk("t5_wr_cnt", 32'(a_wr), 3);
    xact(32'h9000_0020, 32'h0, 0, 4'hF, 0, 0, rd, lat, ge, gr);
    chk("t5_rd_data", rd, 32'hCAFE_F00D);

    // Read counter saturation.
    for (int i = 0; i < 20; i++) xact(32'h9000_0010, 32'h0, 0, 4'hF, 0, 0, rd, lat, ge, gr);
    chk("t6_rd_sat", 32'(a_rd), 15);

    // Second strobe during the wait.
    chk("t6_proto_before", 32'(a_proto), 0);
    xact(32'h9000_0010, 32'h0, 0, 4'hF, 0, 1, rd, lat, ge, gr);
    chk("t6_dup_data", rd, 32'hDEAD_1234);
    chk("t6_dup_lat", lat, 3);
    chk("t6_proto_set", 32'(a_proto), 1);
    repeat (3) @(posedge clk);
    #1 chk("t6_proto_sticky", 32'(a_proto), 1);

    // Fill the randomly addressed words, then random traffic.
    for (int i = 0; i < 9; i++) xact(hit_list[i], $urandom, 1, 4'hF, 0, 0, rd, lat, ge, gr);
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      int ab;
      bit dp;
      if ($urandom_range(0, 99) < 15) a = miss_list[$urandom_range(0, 2)];
      else a = hit_list[$urandom_range(0, 8)] | {30'b0, 2'($urandom)};
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      dp = (ab == 0) && ($urandom_range(0, 19) == 0);
      xact(a, $urandom, 1'($urandom), 4'($urandom), ab, dp, rd, lat, ge, gr);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
